hazard_stall_ctrl: RTL and testbench

- Decode-to-execute pipeline register and stall controller for the 8-register pipelined datapath.
- Registers decoded control and operand fields into the EX stage. On a data hazard it freezes the PC and IR and injects a bubble into EX. It also handles branch flushes.
- Its EX-stage RW and DA outputs drive the hazard detector's RW/DA inputs. That detector's active-high hazard flag (DHS_O) is fed back here as dhs.

---
 rtl/hazard_stall_ctrl_pkg.sv | 18 +
 rtl/hazard_stall_ctrl_if.sv | 35 +++
 rtl/hazard_stall_ctrl_ex_pipe_reg.sv | 50 +++++
 rtl/hazard_stall_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the decode-to-execute stall controller: FSM encoding,
// register-address width and the field values that make up a pipeline bubble.
package hazard_stall_ctrl_pkg;

  localparam int REG_AW = 3;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stall_state_e;

  // A bubble uses destination 0 so the hazard detector can never match on it.
  localparam logic              BUBBLE_VALID = 1'b0;
  localparam logic              BUBBLE_RW    = 1'b0;
  localparam logic              BUBBLE_MD    = 1'b0;
  localparam logic [REG_AW-1:0] BUBBLE_DA    = '0;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Decode-side fields entering the controller and the EX-stage fields it presents.
interface hazard_stall_ctrl_if
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FS_W   = 4
);

  logic              d_valid;
  logic              d_rw;
  logic [REG_AW-1:0] d_da;
  logic              d_md;
  logic [FS_W-1:0]   d_fs;
  logic [DATA_W-1:0] d_bus_a;
  logic [DATA_W-1:0] d_bus_b;

  logic              ex_valid;
  logic              ex_rw;
  logic [REG_AW-1:0] ex_da;
  logic              ex_md;
  logic [FS_W-1:0]   ex_fs;
  logic [DATA_W-1:0] ex_bus_a;
  logic [DATA_W-1:0] ex_bus_b;

  modport master (
    output d_valid, d_rw, d_da, d_md, d_fs, d_bus_a, d_bus_b,
    input  ex_valid, ex_rw, ex_da, ex_md, ex_fs, ex_bus_a, ex_bus_b
  );

  modport slave (
    input  d_valid, d_rw, d_da, d_md, d_fs, d_bus_a, d_bus_b,
    output ex_valid, ex_rw, ex_da, ex_md, ex_fs, ex_bus_a, ex_bus_b
  );

endinterface

// File: rtl/hazard_stall_ctrl_ex_pipe_reg.sv
// EX-stage register bank: loads decoded fields, or clears to a bubble on reset
// or when the controller asks for one.
module ex_pipe_reg
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FS_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              bubble,
  input  logic              d_valid,
  input  logic              d_rw,
  input  logic [REG_AW-1:0] d_da,
  input  logic              d_md,
  input  logic [FS_W-1:0]   d_fs,
  input  logic [DATA_W-1:0] d_bus_a,
  input  logic [DATA_W-1:0] d_bus_b,
  output logic              ex_valid,
  output logic              ex_rw,
  output logic [REG_AW-1:0] ex_da,
  output logic              ex_md,
  output logic [FS_W-1:0]   ex_fs,
  output logic [DATA_W-1:0] ex_bus_a,
  output logic [DATA_W-1:0] ex_bus_b
);

  // Reset and bubble share one path: both leave EX holding a harmless no-op.
  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      ex_valid <= BUBBLE_VALID;
      ex_rw    <= BUBBLE_RW;
      ex_da    <= BUBBLE_DA;
      ex_md    <= BUBBLE_MD;
      ex_fs    <= '0;
      ex_bus_a <= '0;
      ex_bus_b <= '0;
    end else if (load) begin
      ex_valid <= d_valid;
      ex_rw    <= d_rw;
      ex_da    <= d_da;
      ex_md    <= d_md;
      ex_fs    <= d_fs;
      ex_bus_a <= d_bus_a;
      ex_bus_b <= d_bus_b;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-to-execute pipeline register with data-hazard stall and branch-flush
// control, plus stall-length error detection and a saturating stall counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FS_W      = 4,
  parameter int MAX_STALL = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dhs,
  input  logic                 flush,
  hazard_stall_ctrl_if.slave   bus,
  output logic                 pc_en,
  output logic                 ir_en,
  output logic                 stall_err,
  output logic [CNT_W-1:0]     stall_count
);

  // Run counter must reach MAX_STALL+1 without wrapping.
  localparam int RUN_W = (MAX_STALL + 2 > 2) ? $clog2(MAX_STALL + 2) : 1;
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(MAX_STALL + 1);

  stall_state_e     state;
  logic [RUN_W-1:0] run_cnt;
  logic             hz;

  assign hz    = dhs & bus.d_valid & ~flush;
  assign pc_en = ~hz | ~rst_n;
  assign ir_en = ~hz | ~rst_n;

  ex_pipe_reg #(
    .DATA_W (DATA_W),
    .FS_W   (FS_W)
  ) u_ex_pipe_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b1),
    .bubble   (flush | hz),
    .d_valid  (bus.d_valid),
    .d_rw     (bus.d_rw),
    .d_da     (bus.d_da),
    .d_md     (bus.d_md),
    .d_fs     (bus.d_fs),
    .d_bus_a  (bus.d_bus_a),
    .d_bus_b  (bus.d_bus_b),
    .ex_valid (bus.ex_valid),
    .ex_rw    (bus.ex_rw),
    .ex_da    (bus.ex_da),
    .ex_md    (bus.ex_md),
    .ex_fs    (bus.ex_fs),
    .ex_bus_a (bus.ex_bus_a),
    .ex_bus_b (bus.ex_bus_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      run_cnt     <= '0;
      stall_err   <= 1'b0;
      stall_count <= '0;
    end else begin
      if (hz && run_cnt == RUN_LIMIT)
        stall_err <= 1'b1;
      if (hz && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + CNT_W'(1);

      // A taken branch discards any stall in progress.
      if (flush) begin
        state   <= RUN;
        run_cnt <= '0;
      end else begin
        case (state)
          RUN: begin
            if (hz) begin
              state   <= STALL;
              run_cnt <= RUN_W'(1);
            end
          end
          STALL: begin
            if (hz) begin
              if (run_cnt != RUN_SAT)
                run_cnt <= run_cnt + RUN_W'(1);
            end else begin
              state   <= RUN;
              run_cnt <= '0;
            end
          end
          default: begin
            state   <= RUN;
            run_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed vectors push hand-computed
// expectations; a monitor pops one per cycle and compares against the DUT.
module tb_hazard_stall_ctrl;

  typedef struct {
    logic       rst_n;
    logic       dhs;
    logic       flush;
    logic       valid;
    logic       rw;
    logic [2:0] da;
    logic       md;
    logic [3:0] fs;
    logic [7:0] a;
    logic [7:0] b;
  } stim_t;

  typedef struct {
    logic        pc;
    logic        valid;
    logic        rw;
    logic [2:0]  da;
    logic        md;
    logic [3:0]  fs;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        dhs;
  logic        flush;
  logic        pc_en;
  logic        ir_en;
  logic        stall_err;
  logic [15:0] stall_count;

  int   checks;
  int   failures;
  exp_t exp_q[$];

  hazard_stall_ctrl_if #(.DATA_W(8), .FS_W(4)) bus ();

  hazard_stall_ctrl #(
    .DATA_W    (8),
    .FS_W      (4),
    .MAX_STALL (2),
    .CNT_W     (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dhs         (dhs),
    .flush       (flush),
    .bus         (bus),
    .pc_en       (pc_en),
    .ir_en       (ir_en),
    .stall_err   (stall_err),
    .stall_count (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t S(input logic r, input logic h, input logic f, input logic v,
                              input logic w, input logic [2:0] da, input logic md,
                              input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b);
    stim_t s;
    s.rst_n = r; s.dhs = h; s.flush = f; s.valid = v; s.rw = w;
    s.da = da; s.md = md; s.fs = fs; s.a = a; s.b = b;
    return s;
  endfunction

  function automatic exp_t E(input logic pc, input logic v, input logic w, input logic [2:0] da,
                             input logic md, input logic [3:0] fs, input logic [7:0] a,
                             input logic [7:0] b, input logic err, input logic [15:0] cnt);
    exp_t e;
    e.pc = pc; e.valid = v; e.rw = w; e.da = da; e.md = md; e.fs = fs;
    e.a = a; e.b = b; e.err = err; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t B(input logic pc, input logic err, input logic [15:0] cnt);
    return E(pc, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 8'h00, 8'h00, err, cnt);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s, input exp_t e);
    @(negedge clk);
    rst_n       = s.rst_n;
    dhs         = s.dhs;
    flush       = s.flush;
    bus.d_valid = s.valid;
    bus.d_rw    = s.rw;
    bus.d_da    = s.da;
    bus.d_md    = s.md;
    bus.d_fs    = s.fs;
    bus.d_bus_a = s.a;
    bus.d_bus_b = s.b;
    exp_q.push_back(e);
  endtask

  // Monitor: enables are combinational, so sample them mid-cycle; EX fields after the edge.
  initial begin
    logic pc_s;
    logic ir_s;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      pc_s = pc_en;
      ir_s = ir_en;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pc_en",       {31'd0, pc_s},            {31'd0, e.pc});
        checkOutput("ir_en",       {31'd0, ir_s},            {31'd0, e.pc});
        checkOutput("ex_valid",    {31'd0, bus.ex_valid},    {31'd0, e.valid});
        checkOutput("ex_rw",       {31'd0, bus.ex_rw},       {31'd0, e.rw});
        checkOutput("ex_da",       {29'd0, bus.ex_da},       {29'd0, e.da});
        checkOutput("ex_md",       {31'd0, bus.ex_md},       {31'd0, e.md});
        checkOutput("ex_fs",       {28'd0, bus.ex_fs},       {28'd0, e.fs});
        checkOutput("ex_bus_a",    {24'd0, bus.ex_bus_a},    {24'd0, e.a});
        checkOutput("ex_bus_b",    {24'd0, bus.ex_bus_b},    {24'd0, e.b});
        checkOutput("stall_err",   {31'd0, stall_err},       {31'd0, e.err});
        checkOutput("stall_count", {16'd0, stall_count},     {16'd0, e.cnt});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    dhs         = 1'b0;
    flush       = 1'b0;
    bus.d_valid = 1'b0;
    bus.d_rw    = 1'b0;
    bus.d_da    = 3'd0;
    bus.d_md    = 1'b0;
    bus.d_fs    = 4'd0;
    bus.d_bus_a = 8'h00;
    bus.d_bus_b = 8'h00;
    $display("[TB] start");

    // Reset held two cycles with a live hazard request: enables forced high.
    applyStimulus(S(0,1,0,1,1,3'd5,1,4'd7,8'h11,8'h22), B(1,0,16'd0));
    applyStimulus(S(0,1,0,1,1,3'd5,1,4'd7,8'h11,8'h22), B(1,0,16'd0));
    // Normal flow.
    applyStimulus(S(1,0,0,1,1,3'd3,0,4'd2,8'h5A,8'h33), E(1,1,1,3'd3,0,4'd2,8'h5A,8'h33,0,16'd0));
    applyStimulus(S(1,0,0,1,0,3'd6,1,4'd9,8'hC3,8'h0F), E(1,1,0,3'd6,1,4'd9,8'hC3,8'h0F,0,16'd0));
    // Two-cycle hazard, then the held instruction issues.
    applyStimulus(S(1,1,0,1,1,3'd2,0,4'd4,8'hAA,8'h55), B(0,0,16'd1));
    applyStimulus(S(1,1,0,1,1,3'd2,0,4'd4,8'hAA,8'h55), B(0,0,16'd2));
    applyStimulus(S(1,0,0,1,1,3'd2,0,4'd4,8'hAA,8'h55), E(1,1,1,3'd2,0,4'd4,8'hAA,8'h55,0,16'd2));
    // dhs with no valid instruction is ignored.
    applyStimulus(S(1,1,0,0,1,3'd7,0,4'd0,8'h01,8'h00), E(1,0,1,3'd7,0,4'd0,8'h01,8'h00,0,16'd2));
    // Flush in the middle of a stall wins and clears the run length.
    applyStimulus(S(1,1,0,1,1,3'd5,1,4'd3,8'h66,8'h99), B(0,0,16'd3));
    applyStimulus(S(1,1,0,1,1,3'd5,1,4'd3,8'h66,8'h99), B(0,0,16'd4));
    applyStimulus(S(1,1,1,1,1,3'd5,1,4'd3,8'h66,8'h99), B(1,0,16'd4));
    applyStimulus(S(1,1,0,1,1,3'd5,1,4'd3,8'h66,8'h99), B(0,0,16'd5));
    applyStimulus(S(1,1,0,1,1,3'd5,1,4'd3,8'h66,8'h99), B(0,0,16'd6));
    applyStimulus(S(1,0,0,1,1,3'd5,1,4'd3,8'h66,8'h99), E(1,1,1,3'd5,1,4'd3,8'h66,8'h99,0,16'd6));
    // Overlong stall: error on the third stall edge, sticky afterwards.
    applyStimulus(S(1,1,0,1,1,3'd4,0,4'd1,8'h10,8'h20), B(0,0,16'd7));
    applyStimulus(S(1,1,0,1,1,3'd4,0,4'd1,8'h10,8'h20), B(0,0,16'd8));
    applyStimulus(S(1,1,0,1,1,3'd4,0,4'd1,8'h10,8'h20), B(0,1,16'd9));
    applyStimulus(S(1,0,0,1,1,3'd4,0,4'd1,8'h10,8'h20), E(1,1,1,3'd4,0,4'd1,8'h10,8'h20,1,16'd9));
    // Reset in the second stall cycle, then a fresh two-cycle stall must not error.
    applyStimulus(S(1,1,0,1,0,3'd6,0,4'd8,8'hF0,8'h0F), B(0,1,16'd10));
    applyStimulus(S(0,1,0,1,0,3'd6,0,4'd8,8'hF0,8'h0F), B(1,0,16'd0));
    applyStimulus(S(1,1,0,1,0,3'd6,0,4'd8,8'hF0,8'h0F), B(0,0,16'd1));
    applyStimulus(S(1,1,0,1,0,3'd6,0,4'd8,8'hF0,8'h0F), B(0,0,16'd2));
    applyStimulus(S(1,0,0,1,0,3'd6,0,4'd8,8'hF0,8'h0F), E(1,1,0,3'd6,0,4'd8,8'hF0,8'h0F,0,16'd2));
    applyStimulus(S(1,0,0,0,0,3'd0,0,4'd0,8'h00,8'h00), E(1,0,0,3'd0,0,4'd0,8'h00,8'h00,0,16'd2));

    repeat (3) @(negedge clk);
    checkOutput("queue_drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
